// File: rtl/prn_chip_stream.sv
// -----------------------------------------------------------------------------
// prn_chip_stream
//   Streaming multi-channel NavIC L1 SPS ranging-code chip generator.
//   Every channel owns a seed shadow {S0,S1,SC} and a working set {r0,r1,c}.
//   All channels advance together by one chip per accepted beat on a
//   valid/ready stream. A run is one epoch of CODE_LEN chips, or repeated
//   epochs when continuous mode is latched at start. The first and last
//   CAP_N chips of every epoch are captured per channel.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   load, load_ch     seed-load strobe and target channel (IDLE/DONE only)
//   r0_in,r1_in,c_in  seed values
//   start, abort      begin epoch(s) / stop and return to IDLE
//   continuous        repeat epochs with seed reload (latched at start)
//   chip_valid/ready  output stream handshake
//   chips             current chip of each channel (bit k = channel k)
//   chip_idx          chip index within the epoch
//   epoch_last        current beat is the last chip of the epoch
//   busy              FSM not IDLE
//   load_err          one-cycle pulse: load attempted while running
//   first_chips       chips 0..CAP_N-1 per channel, chip 0 in MSB of field
//   last_chips        last CAP_N chips per channel, last chip in LSB of field
// -----------------------------------------------------------------------------
module prn_chip_stream #(
  parameter int N_CH     = 4,
  parameter int REG_W    = 55,
  parameter int C_W      = 5,
  parameter int CODE_LEN = 10230,
  parameter int CAP_N    = 24,
  parameter logic [REG_W-1:0] TAP0 = 55'h0040_0000_80_0000,
  parameter logic [REG_W-1:0] TAP1 = 55'h0000_0040_80_0000,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int IDX_W = $clog2(CODE_LEN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [CH_W-1:0]         load_ch,
  input  logic [REG_W-1:0]        r0_in,
  input  logic [REG_W-1:0]        r1_in,
  input  logic [C_W-1:0]          c_in,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    continuous,
  output logic                    chip_valid,
  input  logic                    chip_ready,
  output logic [N_CH-1:0]         chips,
  output logic [IDX_W-1:0]        chip_idx,
  output logic                    epoch_last,
  output logic                    busy,
  output logic                    load_err,
  output logic [N_CH*CAP_N-1:0]   first_chips,
  output logic [N_CH*CAP_N-1:0]   last_chips
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t state_q, state_d;
  logic   cont_q;

  logic [REG_W-1:0] s0_q [N_CH];
  logic [REG_W-1:0] s1_q [N_CH];
  logic [C_W-1:0]   sc_q [N_CH];
  logic [REG_W-1:0] r0_q [N_CH];
  logic [REG_W-1:0] r1_q [N_CH];
  logic [C_W-1:0]   c_q  [N_CH];

  logic accept, at_last, in_first, in_last, load_ok, start_ok;

  function automatic logic [REG_W-1:0] lfsr_step(input logic [REG_W-1:0] r,
                                                 input logic [REG_W-1:0] tap);
    return {r[REG_W-2:0], ^(r & tap)};
  endfunction

  function automatic logic [C_W-1:0] rotl_c(input logic [C_W-1:0] c);
    return {c[C_W-2:0], c[C_W-1]};
  endfunction

  // valid comes straight from the state register, so chip_ready never
  // reaches it combinationally
  assign chip_valid = (state_q == ST_RUN);
  assign busy       = (state_q != ST_IDLE);
  assign accept     = chip_valid & chip_ready;
  assign at_last    = (chip_idx == IDX_W'(CODE_LEN - 1));
  assign epoch_last = chip_valid & at_last;
  assign in_first   = (chip_idx < IDX_W'(CAP_N));
  assign in_last    = (chip_idx >= IDX_W'(CODE_LEN - CAP_N));
  assign load_ok    = load & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  // a load in the same cycle takes precedence and defers the start
  assign start_ok   = (state_q == ST_IDLE) & start & ~load & ~abort;

  always_comb begin
    chips = '0;
    for (int k = 0; k < N_CH; k++) begin
      chips[k] = r0_q[k][REG_W-1] ^ r1_q[k][REG_W-1] ^ c_q[k][C_W-1];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_RUN;
      ST_RUN:  if (accept && at_last && !cont_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cont_q      <= 1'b0;
      chip_idx    <= '0;
      load_err    <= 1'b0;
      first_chips <= '0;
      last_chips  <= '0;
      for (int k = 0; k < N_CH; k++) begin
        s0_q[k] <= '0;
        s1_q[k] <= '0;
        sc_q[k] <= '0;
        r0_q[k] <= '0;
        r1_q[k] <= '0;
        c_q[k]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      load_err <= load & (state_q == ST_RUN);

      if (abort) begin
        // captures are deliberately left untouched
        chip_idx <= '0;
        for (int k = 0; k < N_CH; k++) begin
          r0_q[k] <= s0_q[k];
          r1_q[k] <= s1_q[k];
          c_q[k]  <= sc_q[k];
        end
      end else if (accept) begin
        for (int k = 0; k < N_CH; k++) begin
          r0_q[k] <= lfsr_step(r0_q[k], TAP0);
          r1_q[k] <= lfsr_step(r1_q[k], TAP1);
          c_q[k]  <= rotl_c(c_q[k]);
          if (in_first)
            first_chips[k*CAP_N +: CAP_N] <= {first_chips[k*CAP_N +: CAP_N-1], chips[k]};
          if (in_last)
            last_chips[k*CAP_N +: CAP_N] <= {last_chips[k*CAP_N +: CAP_N-1], chips[k]};
        end
        if (at_last) begin
          // epoch boundary: rewind to the seeds so the next epoch (or the
          // next run) starts from chip 0 without a bubble
          chip_idx <= '0;
          for (int k = 0; k < N_CH; k++) begin
            r0_q[k] <= s0_q[k];
            r1_q[k] <= s1_q[k];
            c_q[k]  <= sc_q[k];
          end
        end else begin
          chip_idx <= chip_idx + IDX_W'(1);
        end
      end else if (start_ok) begin
        chip_idx <= '0;
        cont_q   <= continuous;
      end

      if (load_ok) begin
        s0_q[load_ch] <= r0_in;
        s1_q[load_ch] <= r1_in;
        sc_q[load_ch] <= c_in;
        r0_q[load_ch] <= r0_in;
        r1_q[load_ch] <= r1_in;
        c_q[load_ch]  <= c_in;
      end
    end
  end

endmodule
